// File: rtl/tmds_channel_decoder.sv
// ---------------------------------------------------------------------------
// tmds_channel_decoder
//
// Receive side of one TMDS channel (blue, green or red). Raw 10-bit words
// arrive from a deserializer on the pixel clock with an unknown bit phase.
// The block searches bit-slip offsets 0..9 until it sees a run of control
// tokens at one offset, then locks. Each aligned symbol is decoded either to a
// pixel byte (de=1) or to the two control bits c0/c1 (de=0).
//
// Ports
//   clk       in   pixel clock; all logic is on the rising edge
//   reset     in   synchronous, active-high; overrides everything else
//   raw_word  in   [9:0] deserialized bits, bit 0 is the first on the wire
//   data      out  [7:0] decoded pixel byte (0 outside active video)
//   c0, c1    out  control bits (hsync/vsync on channel 0)
//   de        out  1 = data valid, 0 = control period or not locked
//   locked    out  symbol alignment acquired
//   offset    out  [3:0] current bit-slip offset, 0..9
//
// Timing
//   window = {raw_word, prev}; the selected 10-bit symbol passes through two
//   registers (stage 1, then the output stage), so outputs follow the
//   alignment window by exactly two clocks whatever the state. At offset 0
//   the symbol sits entirely in prev, which is itself one clock behind
//   raw_word.
// ---------------------------------------------------------------------------
module tmds_channel_decoder #(
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_word,
  output logic [7:0] data,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int unsigned RUN_W = $clog2(CTRL_RUN + 1);
  localparam int unsigned TO_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;

  localparam logic [RUN_W-1:0] RUN_FULL   = RUN_W'(CTRL_RUN);
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(SEARCH_WINDOW - 1);
  localparam logic [TO_W-1:0]  TO_ONE     = TO_W'(1);
  localparam logic [3:0]       OFFSET_MAX = 4'd9;

  // The four DVI control tokens, written MSB first.
  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic       hit;   // symbol is one of the four control tokens
    logic [1:0] ctl;   // {c1, c0} carried by the token
  } token_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic token_t match_token(input logic [9:0] sym);
    token_t t;
    t.hit = 1'b1;
    t.ctl = 2'b00;
    case (sym)
      TOK_00:  t.ctl = 2'b00;
      TOK_01:  t.ctl = 2'b01;
      TOK_10:  t.ctl = 2'b10;
      TOK_11:  t.ctl = 2'b11;
      default: t.hit = 1'b0;
    endcase
    return t;
  endfunction

  // Undo the transmitter's optional inversion (bit 9) and its XOR/XNOR
  // transition chain (bit 8). Codes a real transmitter never emits still go
  // through the same formula; there is no error flag.
  function automatic logic [7:0] tmds_decode(input logic [9:0] sym);
    logic [7:0] b;
    logic [7:0] d;
    b    = sym[9] ? ~sym[7:0] : sym[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = sym[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    end
    return d;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [9:0]       prev_q;
  logic [9:0]       s1_q,   s1_d;
  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q,  run_d;
  logic [TO_W-1:0]  to_q,   to_d;
  logic [3:0]       off_q,  off_d;
  logic [7:0]       data_q, data_d;
  logic             c0_q,   c0_d;
  logic             c1_q,   c1_d;
  logic             de_q,   de_d;

  logic [19:0]      window;
  token_t           tok;
  logic             run_full;

  // Older word in the low half: a symbol starting at bit 'offset' of prev
  // finishes in the low bits of the current raw_word.
  assign window = {raw_word, prev_q};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    s1_d     = 10'(window >> off_q);
    tok      = match_token(s1_q);
    state_d  = state_q;
    off_d    = off_q;
    to_d     = to_q + TO_ONE;
    data_d   = 8'h00;
    de_d     = 1'b0;
    c0_d     = c0_q;
    c1_d     = c1_q;

    // Length of the current unbroken token run, saturating at CTRL_RUN.
    if (!tok.hit) begin
      run_d = '0;
    end else if (run_q == RUN_FULL) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RUN_ONE;
    end
    run_full = (run_d == RUN_FULL);

    case (state_q)
      ST_SEARCH: begin
        // A qualifying run takes priority over stepping the offset.
        if (run_full) begin
          state_d = ST_LOCKED;
          to_d    = '0;
        end else if (to_q == TO_LAST) begin
          off_d = (off_q == OFFSET_MAX) ? 4'd0 : off_q + 4'd1;
          to_d  = '0;
          run_d = '0;
        end
      end
      ST_LOCKED: begin
        // Offset is frozen; a full token run restarts the loss timer.
        if (run_full) begin
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          state_d = ST_SEARCH;
          to_d    = '0;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase

    // Outputs follow the state being entered, so 'locked' and the decoded
    // symbol it qualifies always appear together.
    if (state_d != ST_LOCKED) begin
      c0_d = 1'b0;
      c1_d = 1'b0;
    end else if (tok.hit) begin
      {c1_d, c0_d} = tok.ctl;
    end else begin
      de_d   = 1'b1;
      data_d = tmds_decode(s1_q);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    if (reset) begin
      prev_q  <= '0;
      s1_q    <= '0;
      state_q <= ST_SEARCH;
      run_q   <= '0;
      to_q    <= '0;
      off_q   <= '0;
      data_q  <= '0;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      prev_q  <= raw_word;
      s1_q    <= s1_d;
      state_q <= state_d;
      run_q   <= run_d;
      to_q    <= to_d;
      off_q   <= off_d;
      data_q  <= data_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      de_q    <= de_d;
    end
  end

  assign data   = data_q;
  assign c0     = c0_q;
  assign c1     = c1_q;
  assign de     = de_q;
  assign locked = (state_q == ST_LOCKED);
  assign offset = off_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_channel_decoder
//
// Serial-level stimulus: symbols (control tokens or bytes run through a full
// TMDS encoder with running disparity) are appended to a bit stream that may
// start with a few junk bits, and the stream is cut into 10-bit raw words.
// A reference model tracks the receiver's alignment and lock rules with plain
// integers; each driven cycle pushes the expected outputs for the next cycle
// into a queue that an independent monitor pops and compares at negedge.
// ---------------------------------------------------------------------------
module tb_tmds_channel_decoder;

  localparam int CTRL_RUN = 8;
  localparam int SW       = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] raw_word;
  logic [7:0] data;
  logic       c0, c1, de, locked;
  logic [3:0] offset;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .CTRL_RUN      (CTRL_RUN),
    .SEARCH_WINDOW (SW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_word (raw_word),
    .data     (data),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
    .locked   (locked),
    .offset   (offset)
  );

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  typedef struct {
    int         tgt;
    logic [7:0] data;
    logic       c0;
    logic       c1;
    logic       de;
    logic       locked;
    logic [3:0] offset;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  logic [9:0] tokens [4] = '{10'b1101010100, 10'b0010101011,
                             10'b0101010100, 10'b1010101011};
  bit ser_q[$];
  int disp = 0;

  // Reference model state
  bit         m_locked;
  int         m_run, m_to, m_off;
  logic       m_c0, m_c1;
  logic [9:0] m_prev, m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference functions
  // -------------------------------------------------------------------------
  function automatic int ref_token(input logic [9:0] q);
    for (int k = 0; k < 4; k++) begin
      if (q == tokens[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] x;
    b = q[7:0] ^ {8{q[9]}};
    x = b ^ (b << 1);
    if (!q[8]) x = ~x;
    x[0] = b[0];
    return x;
  endfunction

  // Full DVI transmitter encoding of one byte.
  task automatic tmds_encode(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1, n0;
    n1d   = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (disp == 0 || n1 == n0) begin
      q    = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      disp = disp + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
      q    = {1'b1, qm[8], ~qm[7:0]};
      disp = disp + (qm[8] ? 2 : 0) + (n0 - n1);
    end else begin
      q    = {1'b0, qm[8], qm[7:0]};
      disp = disp - (qm[8] ? 0 : 2) + (n1 - n0);
    end
  endtask

  // Advance the model by one clock edge and queue the outputs it predicts.
  task automatic model_cycle(input logic [9:0] w, input logic rst);
    exp_t       e;
    int         tk;
    logic [19:0] win;
    logic [9:0] sym;
    e.tgt = cyc + 1;
    if (rst) begin
      m_locked = 1'b0; m_run = 0; m_to = 0; m_off = 0;
      m_c0 = 1'b0; m_c1 = 1'b0; m_prev = '0; m_pend = '0;
      e.data = '0; e.c0 = 1'b0; e.c1 = 1'b0; e.de = 1'b0;
      e.locked = 1'b0; e.offset = '0;
    end else begin
      win = {w, m_prev};
      sym = 10'(win >> m_off);
      tk  = ref_token(m_pend);
      m_run = (tk >= 0) ? ((m_run < CTRL_RUN) ? m_run + 1 : CTRL_RUN) : 0;
      if (!m_locked) begin
        if (m_run == CTRL_RUN) begin
          m_locked = 1'b1; m_to = 0;
        end else if (m_to == SW - 1) begin
          m_off = (m_off + 1) % 10; m_to = 0; m_run = 0;
        end else begin
          m_to++;
        end
      end else begin
        if (m_run == CTRL_RUN) begin
          m_to = 0;
        end else if (m_to == SW - 1) begin
          m_locked = 1'b0; m_to = 0; m_run = 0;
        end else begin
          m_to++;
        end
      end
      e.data = '0;
      e.de   = 1'b0;
      if (!m_locked) begin
        m_c0 = 1'b0; m_c1 = 1'b0;
      end else if (tk >= 0) begin
        {m_c1, m_c0} = 2'(tk);
      end else begin
        e.de   = 1'b1;
        e.data = ref_decode(m_pend);
      end
      e.c0 = m_c0; e.c1 = m_c1;
      e.locked = m_locked;
      e.offset = 4'(m_off);
      m_pend = sym;
      m_prev = w;
    end
    exp_q.push_back(e);
  endtask

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  task automatic drive(input logic [9:0] w, input logic rst);
    @(posedge clk);
    #1;
    cyc++;
    raw_word = w;
    reset    = rst;
    model_cycle(w, rst);
  endtask

  task automatic tx_sym(input logic [9:0] s);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) ser_q.push_back(s[i]);
    while (ser_q.size() >= 10) begin
      for (int i = 0; i < 10; i++) w[i] = ser_q.pop_front();
      drive(w, 1'b0);
    end
  endtask

  task automatic tx_token(input int k);
    tx_sym(tokens[k]);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    logic [9:0] q;
    tmds_encode(b, q);
    tx_sym(q);
  endtask

  // Start a fresh serial stream delayed by 'slip' junk bits.
  task automatic start_stream(input int slip);
    ser_q.delete();
    for (int i = 0; i < slip; i++) ser_q.push_back(1'($urandom));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(10'($urandom), 1'b1);
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard monitor
  // -------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({data, c1, c0, de, locked, offset} !==
            {e.data, e.c1, e.c0, e.de, e.locked, e.offset}) begin
          n_fail++;
          $display("FAIL scoreboard cyc %0d: got data=%h c1c0=%b%b de=%b locked=%b offset=%0d, expected data=%h c1c0=%b%b de=%b locked=%b offset=%0d",
                   cyc, data, c1, c0, de, locked, offset,
                   e.data, e.c1, e.c0, e.de, e.locked, e.offset);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [7:0] rb;
    logic [7:0] bytes [4];
    reset    = 1'b1;
    raw_word = '0;

    // Reset state
    do_reset(2);
    @(negedge clk);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_offset", 32'(offset), 32'd0);
    check("reset_outputs", {de, c1, c0, data}, 32'd0);

    // Aligned stream: lock at offset 0
    start_stream(0);
    repeat (20) tx_token(0);
    @(negedge clk);
    check("aligned_locked", 32'(locked), 32'd1);
    check("aligned_offset", 32'(offset), 32'd0);
    check("aligned_ctrl", {de, c1, c0}, 32'd0);

    // Data decode: literal codes, then repeated encoded bytes
    tx_sym(10'b0100000000);
    tx_sym(10'b1011111111);
    tx_sym(10'b0111110000);
    rb = 8'($urandom);
    bytes = '{8'h00, 8'hFF, 8'h10, rb};
    for (int k = 0; k < 4; k++) begin
      repeat (4) tx_byte(bytes[k]);
      @(negedge clk);
      check("data_byte", {de, data}, {23'd0, 1'b1, bytes[k]});
    end
    repeat (12) tx_byte(8'($urandom));

    // Control values: each token held long enough to be seen
    for (int k = 0; k < 4; k++) begin
      repeat (4) tx_token(k);
      @(negedge clk);
      check("ctrl_value", {de, data, c1, c0}, 32'(k));
    end
    repeat (16) tx_token(int'($urandom_range(0, 3)));

    // Bit-slipped stream: 3 bits late, offset must walk 0..3
    do_reset(1);
    start_stream(3);
    repeat (3 * SW + 30) tx_token(0);
    @(negedge clk);
    check("slip3_locked", 32'(locked), 32'd1);
    check("slip3_offset", 32'(offset), 32'd3);
    repeat (4) tx_byte(8'h5A);
    @(negedge clk);
    check("slip3_data", {de, data}, {23'd0, 1'b1, 8'h5A});
    repeat (6) tx_byte(8'($urandom));

    // Lock loss on a pure data stream, offset retained
    repeat (70) tx_byte(8'($urandom));
    @(negedge clk);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_offset", 32'(offset), 32'd3);
    check("loss_outputs", {de, c1, c0, data}, 32'd0);

    // 7 tokens do not relock, 8 do
    repeat (7) tx_token(1);
    repeat (3) tx_byte(8'($urandom));
    @(negedge clk);
    check("run7_locked", 32'(locked), 32'd0);
    repeat (8) tx_token(2);
    repeat (3) tx_byte(8'($urandom));
    @(negedge clk);
    check("run8_locked", 32'(locked), 32'd1);
    check("run8_offset", 32'(offset), 32'd3);

    // Mid-operation reset while locked at offset 5
    do_reset(1);
    start_stream(5);
    repeat (5 * SW + 30) tx_token(0);
    @(negedge clk);
    check("slip5_locked", 32'(locked), 32'd1);
    check("slip5_offset", 32'(offset), 32'd5);
    drive(10'($urandom), 1'b1);
    tx_token(3);
    @(negedge clk);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_offset", 32'(offset), 32'd0);
    check("midrst_outputs", {de, c1, c0, data}, 32'd0);
    repeat (6) tx_token(3);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
